// File: rtl/fe2de_queue_if.sv
// Fetch-to-decode queue interface: flush sources, fetch-side enqueue bundle and decode-side head bundle.
interface fe2de_queue_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CNTW = $clog2(DEPTH) + 1;

   logic            fet_flush;
   logic            branch_predict_err;
   logic            mem2wb_exp_ffout;
   logic            interrupt;
   logic            fe_valid;
   logic            fe_ready;
   logic [XLEN-1:0] fetch_pc;
   logic [ILEN-1:0] fetch_instr;
   logic            fet_is_x1;
   logic            fet_is_xn;
   logic            predict_bxxtaken;
   logic            fe2de_rv16;
   logic            cross_bd_kill;
   logic            de_stall;
   logic            de_valid;
   logic [XLEN-1:0] fe2de_pc_ffout;
   logic [ILEN-1:0] fe2de_instr_ffout;
   logic            fet_is_x1_ffout;
   logic            fet_is_xn_ffout;
   logic            fe2de_predict_bxxtaken_ffout;
   logic            fe2de_rv16_ffout;
   logic            fet_stall;
   logic [CNTW-1:0] q_count;

   modport slave (
      input  fet_flush, branch_predict_err, mem2wb_exp_ffout, interrupt,
      input  fe_valid, fetch_pc, fetch_instr, fet_is_x1, fet_is_xn,
      input  predict_bxxtaken, fe2de_rv16, cross_bd_kill, de_stall,
      output fe_ready, de_valid, fe2de_pc_ffout, fe2de_instr_ffout,
      output fet_is_x1_ffout, fet_is_xn_ffout, fe2de_predict_bxxtaken_ffout,
      output fe2de_rv16_ffout, fet_stall, q_count
   );

   modport master (
      output fet_flush, branch_predict_err, mem2wb_exp_ffout, interrupt,
      output fe_valid, fetch_pc, fetch_instr, fet_is_x1, fet_is_xn,
      output predict_bxxtaken, fe2de_rv16, cross_bd_kill, de_stall,
      input  fe_ready, de_valid, fe2de_pc_ffout, fe2de_instr_ffout,
      input  fet_is_x1_ffout, fet_is_xn_ffout, fe2de_predict_bxxtaken_ffout,
      input  fe2de_rv16_ffout, fet_stall, q_count
   );
endinterface

// File: rtl/fe2de_queue.sv
// DEPTH-entry fetch-to-decode instruction FIFO with flush and NOP bubble on empty.
// Optional FE2DE_BYPASS_EN: empty queue forwards fetch inputs to decode in the same cycle.
module fe2de_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input logic           clk,
   input logic           cpurst_n,
   fe2de_queue_if.slave  bus
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            is_x1;
      logic            is_xn;
      logic            bxx_taken;
      logic            rv16;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;

   logic   flush;
   logic   full;
   logic   empty;
   logic   byp;
   logic   enq;
   logic   deq;
   logic   valid;
   entry_t fe_entry;
   entry_t head;

   assign flush = bus.fet_flush | bus.branch_predict_err | bus.mem2wb_exp_ffout | bus.interrupt;
   assign full  = (count == CNTW'(DEPTH));
   assign empty = (count == '0);

`ifdef FE2DE_BYPASS_EN
   assign byp = empty & bus.fe_valid & ~flush;
`else
   assign byp = 1'b0;
`endif

   // A bypassed instruction that decode consumes immediately never occupies a slot.
   assign enq = bus.fe_valid & ~full & ~flush & ~(byp & ~bus.de_stall);
   assign deq = ~empty & ~bus.de_stall & ~flush;

   always_comb begin
      fe_entry           = '0;
      fe_entry.pc        = bus.fetch_pc;
      fe_entry.instr     = bus.cross_bd_kill ? '0 : bus.fetch_instr;
      fe_entry.is_x1     = bus.fet_is_x1;
      fe_entry.is_xn     = bus.fet_is_xn;
      fe_entry.bxx_taken = bus.predict_bxxtaken;
      fe_entry.rv16      = bus.fe2de_rv16;
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            mem[wr_ptr] <= fe_entry;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CNTW'(enq) - CNTW'(deq);
      end
   end

   // Head view: bypassed fetch entry or stored head; everything but pc masked to NOP when invalid.
   always_comb begin
      valid = ~empty | byp;
      head  = byp ? fe_entry : mem[rd_ptr];
      if (!valid) begin
         head.instr     = '0;
         head.is_x1     = 1'b0;
         head.is_xn     = 1'b0;
         head.bxx_taken = 1'b0;
         head.rv16      = 1'b0;
      end
   end

   assign bus.de_valid                     = valid;
   assign bus.fe2de_pc_ffout               = head.pc;
   assign bus.fe2de_instr_ffout            = head.instr;
   assign bus.fet_is_x1_ffout              = head.is_x1;
   assign bus.fet_is_xn_ffout              = head.is_xn;
   assign bus.fe2de_predict_bxxtaken_ffout = head.bxx_taken;
   assign bus.fe2de_rv16_ffout             = head.rv16;
   assign bus.fe_ready                     = ~full;
   assign bus.fet_stall                    = full;
   assign bus.q_count                      = count;
endmodule

// File: tb/tb_fe2de_queue.sv
// Directed bench for fe2de_queue (DEPTH=2): reset, streaming, fill/drain, flush, kill, optional bypass.
module tb_fe2de_queue;
   logic clk;
   logic cpurst_n;
   int   vectors;
   int   errors;

   fe2de_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(2)) bus ();

   fe2de_queue #(.XLEN(32), .ILEN(32), .DEPTH(2)) dut (
      .clk      (clk),
      .cpurst_n (cpurst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_fetch(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      bus.fe_valid    = v;
      bus.fetch_pc    = pc;
      bus.fetch_instr = instr;
   endtask

   task automatic test_reset;
      cpurst_n = 1'b1;
      #2 cpurst_n = 1'b0;
      #1;
      vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", bus.q_count); end
      vectors++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.de_valid); end
      vectors++; if (bus.fe_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", bus.fe_ready); end
      vectors++; if (bus.fe2de_pc_ffout !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h want=0", bus.fe2de_pc_ffout); end
      @(negedge clk) cpurst_n = 1'b1;
      bus.de_stall = 1'b1;
      drive_fetch(1'b1, 32'h80, 32'h13);
      @(negedge clk) drive_fetch(1'b1, 32'h84, 32'h13);
      @(negedge clk) drive_fetch(1'b0, 32'h0, 32'h0);
      #1;
      vectors++; if (bus.q_count !== 2'd2) begin errors++; $display("FAIL rst_pre_count got=%0d want=2", bus.q_count); end
      cpurst_n = 1'b0;
      #1;
      vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL rst_mid_count got=%0d want=0", bus.q_count); end
      vectors++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", bus.de_valid); end
      vectors++; if (bus.fe2de_instr_ffout !== 32'h0) begin errors++; $display("FAIL rst_mid_instr got=%h want=0", bus.fe2de_instr_ffout); end
      vectors++; if (bus.fe_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", bus.fe_ready); end
      vectors++; if (bus.fe2de_pc_ffout !== 32'h0) begin errors++; $display("FAIL rst_mid_pc got=%h want=0", bus.fe2de_pc_ffout); end
      bus.de_stall = 1'b0;
      @(negedge clk) cpurst_n = 1'b1;
   endtask

   task automatic test_stream;
      logic [31:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      bus.de_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) drive_fetch(1'b1, pcs[i], 32'h1000 + 32'(i));
         else       drive_fetch(1'b0, 32'h0, 32'h0);
         #1;
         if (i == 0) begin
            vectors++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got=%b want=0", bus.de_valid); end
         end else begin
            vectors++; if (bus.de_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got=%b want=1", i, bus.de_valid); end
            vectors++; if (bus.fe2de_pc_ffout !== pcs[i-1]) begin errors++; $display("FAIL stream_pc%0d got=%h want=%h", i, bus.fe2de_pc_ffout, pcs[i-1]); end
            vectors++; if (bus.fe2de_instr_ffout !== 32'h1000 + 32'(i-1)) begin errors++; $display("FAIL stream_instr%0d got=%h want=%h", i, bus.fe2de_instr_ffout, 32'h1000 + 32'(i-1)); end
            vectors++; if (bus.q_count !== 2'd1) begin errors++; $display("FAIL stream_count%0d got=%0d want=1", i, bus.q_count); end
         end
      end
      @(negedge clk); #1;
      vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL stream_drain got=%0d want=0", bus.q_count); end
   endtask

   task automatic test_fill;
      bus.de_stall = 1'b1;
      drive_fetch(1'b1, 32'h200, 32'h2000);
      @(negedge clk) drive_fetch(1'b1, 32'h204, 32'h2004);
      #1;
      vectors++; if (bus.fe_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got=%b want=1", bus.fe_ready); end
      @(negedge clk) drive_fetch(1'b1, 32'h208, 32'h2008);
      #1;
      vectors++; if (bus.q_count !== 2'd2) begin errors++; $display("FAIL fill_count got=%0d want=2", bus.q_count); end
      vectors++; if (bus.fe_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", bus.fe_ready); end
      vectors++; if (bus.fet_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got=%b want=1", bus.fet_stall); end
      @(negedge clk);
      bus.de_stall = 1'b0;
      drive_fetch(1'b1, 32'h20c, 32'h200c);
      #1;
      vectors++; if (bus.fe2de_pc_ffout !== 32'h200) begin errors++; $display("FAIL fill_head0 got=%h want=200", bus.fe2de_pc_ffout); end
      vectors++; if (bus.fe_ready !== 1'b0) begin errors++; $display("FAIL fill_noready got=%b want=0", bus.fe_ready); end
      @(negedge clk); #1;
      vectors++; if (bus.fe2de_pc_ffout !== 32'h204) begin errors++; $display("FAIL fill_head1 got=%h want=204", bus.fe2de_pc_ffout); end
      vectors++; if (bus.q_count !== 2'd1) begin errors++; $display("FAIL fill_count1 got=%0d want=1", bus.q_count); end
      vectors++; if (bus.fe_ready !== 1'b1) begin errors++; $display("FAIL fill_ready2 got=%b want=1", bus.fe_ready); end
      @(negedge clk) drive_fetch(1'b0, 32'h0, 32'h0);
      #1;
      vectors++; if (bus.fe2de_pc_ffout !== 32'h20c) begin errors++; $display("FAIL fill_head2 got=%h want=20c", bus.fe2de_pc_ffout); end
      vectors++; if (bus.q_count !== 2'd1) begin errors++; $display("FAIL fill_count2 got=%0d want=1", bus.q_count); end
      @(negedge clk); #1;
      vectors++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b want=0", bus.de_valid); end
   endtask

   task automatic test_flush;
      for (int s = 0; s < 4; s++) begin
         bus.de_stall = 1'b1;
         drive_fetch(1'b1, 32'h500, 32'h5000);
         @(negedge clk) drive_fetch(1'b1, 32'h504, 32'h5004);
         @(negedge clk) drive_fetch(1'b1, 32'h508, 32'h5008);
         bus.de_stall = 1'b0;
         case (s)
            0: bus.interrupt          = 1'b1;
            1: bus.fet_flush          = 1'b1;
            2: bus.branch_predict_err = 1'b1;
            default: bus.mem2wb_exp_ffout = 1'b1;
         endcase
         @(negedge clk);
         bus.interrupt = 1'b0; bus.fet_flush = 1'b0;
         bus.branch_predict_err = 1'b0; bus.mem2wb_exp_ffout = 1'b0;
         drive_fetch(1'b0, 32'h0, 32'h0);
         #1;
         vectors++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL flush%0d_valid got=%b want=0", s, bus.de_valid); end
         vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL flush%0d_count got=%0d want=0", s, bus.q_count); end
         vectors++; if (bus.fe2de_instr_ffout !== 32'h0) begin errors++; $display("FAIL flush%0d_instr got=%h want=0", s, bus.fe2de_instr_ffout); end
         @(negedge clk); #1;
         vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL flush%0d_drop got=%0d want=0", s, bus.q_count); end
      end
   endtask

   task automatic test_kill;
      bus.de_stall = 1'b0;
      drive_fetch(1'b1, 32'h300, 32'h00a00093);
      bus.cross_bd_kill = 1'b1; bus.fe2de_rv16 = 1'b1;
      bus.fet_is_x1 = 1'b1; bus.predict_bxxtaken = 1'b1;
      @(negedge clk);
      drive_fetch(1'b0, 32'h0, 32'h0);
      bus.cross_bd_kill = 1'b0; bus.fe2de_rv16 = 1'b0;
      bus.fet_is_x1 = 1'b0; bus.predict_bxxtaken = 1'b0;
      #1;
      vectors++; if (bus.de_valid !== 1'b1) begin errors++; $display("FAIL kill_valid got=%b want=1", bus.de_valid); end
      vectors++; if (bus.fe2de_instr_ffout !== 32'h0) begin errors++; $display("FAIL kill_instr got=%h want=0", bus.fe2de_instr_ffout); end
      vectors++; if (bus.fe2de_pc_ffout !== 32'h300) begin errors++; $display("FAIL kill_pc got=%h want=300", bus.fe2de_pc_ffout); end
      vectors++; if (bus.fe2de_rv16_ffout !== 1'b1) begin errors++; $display("FAIL kill_rv16 got=%b want=1", bus.fe2de_rv16_ffout); end
      vectors++; if (bus.fet_is_x1_ffout !== 1'b1) begin errors++; $display("FAIL kill_x1 got=%b want=1", bus.fet_is_x1_ffout); end
      vectors++; if (bus.fet_is_xn_ffout !== 1'b0) begin errors++; $display("FAIL kill_xn got=%b want=0", bus.fet_is_xn_ffout); end
      vectors++; if (bus.fe2de_predict_bxxtaken_ffout !== 1'b1) begin errors++; $display("FAIL kill_bt got=%b want=1", bus.fe2de_predict_bxxtaken_ffout); end
      @(negedge clk); #1;
      vectors++; if (bus.fe2de_rv16_ffout !== 1'b0) begin errors++; $display("FAIL kill_mask got=%b want=0", bus.fe2de_rv16_ffout); end
   endtask

`ifdef FE2DE_BYPASS_EN
   task automatic test_bypass;
      bus.de_stall = 1'b0;
      drive_fetch(1'b1, 32'h400, 32'h4000);
      #1;
      vectors++; if (bus.de_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got=%b want=1", bus.de_valid); end
      vectors++; if (bus.fe2de_pc_ffout !== 32'h400) begin errors++; $display("FAIL byp_pc got=%h want=400", bus.fe2de_pc_ffout); end
      @(negedge clk);
      bus.de_stall = 1'b1;
      drive_fetch(1'b1, 32'h404, 32'h4004);
      #1;
      vectors++; if (bus.q_count !== 2'd0) begin errors++; $display("FAIL byp_count0 got=%0d want=0", bus.q_count); end
      vectors++; if (bus.de_valid !== 1'b1) begin errors++; $display("FAIL byp_valid2 got=%b want=1", bus.de_valid); end
      @(negedge clk);
      drive_fetch(1'b0, 32'h0, 32'h0);
      #1;
      vectors++; if (bus.q_count !== 2'd1) begin errors++; $display("FAIL byp_count1 got=%0d want=1", bus.q_count); end
      vectors++; if (bus.fe2de_pc_ffout !== 32'h404) begin errors++; $display("FAIL byp_head got=%h want=404", bus.fe2de_pc_ffout); end
      bus.de_stall = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      vectors = 0;
      errors  = 0;
      cpurst_n = 1'b1;
      bus.fet_flush = 1'b0; bus.branch_predict_err = 1'b0;
      bus.mem2wb_exp_ffout = 1'b0; bus.interrupt = 1'b0;
      bus.fe_valid = 1'b0; bus.fetch_pc = '0; bus.fetch_instr = '0;
      bus.fet_is_x1 = 1'b0; bus.fet_is_xn = 1'b0; bus.predict_bxxtaken = 1'b0;
      bus.fe2de_rv16 = 1'b0; bus.cross_bd_kill = 1'b0; bus.de_stall = 1'b0;
      test_reset();
      test_stream();
      test_fill();
      test_flush();
      test_kill();
`ifdef FE2DE_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
